// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI transaction sequencer.
// State encoding is fixed so it can be probed and compared against documentation.
package spi_pkg;

  localparam int BYTE_W           = 8;
  localparam int CS_SETUP_DEFAULT = 2;
  localparam int CS_HOLD_DEFAULT  = 2;

  typedef enum logic [2:0] {
    IDLE        = 3'd0,
    CS_SETUP    = 3'd1,
    ISSUE       = 3'd2,
    WAIT_ACCEPT = 3'd3,
    WAIT_BYTE   = 3'd4,
    CS_HOLD     = 3'd5,
    DONE        = 3'd6
  } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO, write-to-read latency 1 cycle, head shown combinationally.
// Backpressure: push ignored when full, pop ignored when empty; flush empties it.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_flush,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dat,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_push;
  logic             w_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                   (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;
  assign o_dat   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst || i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_dat;
  end

endmodule

// File: rtl/spi_transaction_sequencer.sv
// Multi-byte SPI burst engine feeding a single-byte controller; owns chip select, buffers TX/RX bytes.
// Optional per-byte watchdog enabled by SPI_SEQ_TIMEOUT_EN; otherwise the block waits indefinitely.
module spi_transaction_sequencer
  import spi_pkg::*;
#(
  parameter int FIFO_DEPTH      = 16,
  parameter int CS_SETUP_CYCLES = CS_SETUP_DEFAULT,
  parameter int CS_HOLD_CYCLES  = CS_HOLD_DEFAULT,
  parameter int TIMEOUT_CYCLES  = 1023
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [BYTE_W-1:0] i_cmd_len,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic [BYTE_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic [BYTE_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  output logic [BYTE_W-1:0] o_spi_tx,
  output logic              o_spi_tx_valid,
  input  logic              i_spi_ready,
  input  logic [BYTE_W-1:0] i_spi_rx,
  input  logic              i_spi_rx_valid,
  output logic              o_cs_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_timeout
);

  state_t            r_state;
  logic [BYTE_W-1:0] r_remaining;
  logic [3:0]        r_cnt;
  logic              r_cs_n;
  logic [BYTE_W-1:0] r_spi_tx;
  logic              r_spi_tx_valid;
  logic              r_busy;
  logic              r_done;
  logic              r_timeout;

  logic [BYTE_W-1:0] w_tx_dat;
  logic              w_tx_full;
  logic              w_tx_empty;
  logic              w_rx_full;
  logic              w_rx_empty;
  logic              w_cmd_acc;
  logic              w_issue;
  logic              w_rx_push;
  logic              w_wd_hit;

  assign o_cmd_ready    = (r_state == IDLE) && !i_rst;
  assign o_tx_ready     = !w_tx_full;
  assign o_rx_valid     = !w_rx_empty;
  assign o_cs_n         = r_cs_n;
  assign o_spi_tx       = r_spi_tx;
  assign o_spi_tx_valid = r_spi_tx_valid;
  assign o_busy         = r_busy;
  assign o_done         = r_done;
  assign o_timeout      = r_timeout;

  assign w_cmd_acc = i_cmd_valid && o_cmd_ready;
  // RX space is reserved before issuing so a returning byte can never be dropped.
  assign w_issue   = (r_state == ISSUE) && !w_tx_empty && !w_rx_full && i_spi_ready;
  assign w_rx_push = (r_state == WAIT_BYTE) && i_spi_rx_valid && !w_wd_hit;

`ifdef SPI_SEQ_TIMEOUT_EN
  localparam int WD_W = ($clog2(TIMEOUT_CYCLES + 1) > 10) ? $clog2(TIMEOUT_CYCLES + 1) : 10;

  logic [WD_W-1:0] r_wd;

  assign w_wd_hit = ((r_state == WAIT_ACCEPT) || (r_state == WAIT_BYTE)) &&
                    (r_wd == WD_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || w_issue) begin
      r_wd <= '0;
    end else if ((r_state == WAIT_ACCEPT) || (r_state == WAIT_BYTE)) begin
      r_wd <= r_wd + 1'b1;
    end
  end
`else
  // Watchdog absent; the parameter is still referenced so both builds share one interface.
  assign w_wd_hit = (TIMEOUT_CYCLES < 0);
`endif

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (w_wd_hit),
    .i_push  (i_tx_valid),
    .i_dat   (i_tx_data),
    .i_pop   (w_issue),
    .o_dat   (w_tx_dat),
    .o_full  (w_tx_full),
    .o_empty (w_tx_empty)
  );

  sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_flush (1'b0),
    .i_push  (w_rx_push),
    .i_dat   (i_spi_rx),
    .i_pop   (i_rx_ready),
    .o_dat   (o_rx_data),
    .o_full  (w_rx_full),
    .o_empty (w_rx_empty)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= IDLE;
      r_remaining    <= '0;
      r_cnt          <= '0;
      r_cs_n         <= 1'b1;
      r_spi_tx       <= '0;
      r_spi_tx_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
    end else begin
      r_spi_tx_valid <= 1'b0;
      r_done         <= 1'b0;
      r_timeout      <= 1'b0;
      if (w_wd_hit) begin
        r_timeout <= 1'b1;
        r_busy    <= 1'b0;
        r_state   <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            r_cs_n <= 1'b1;
            if (w_cmd_acc) begin
              r_remaining <= i_cmd_len;
              r_busy      <= 1'b1;
              r_cnt       <= 4'(CS_SETUP_CYCLES);
              r_state     <= (i_cmd_len == '0) ? DONE : CS_SETUP;
            end
          end
          CS_SETUP: begin
            r_cs_n <= 1'b0;
            if (r_cnt == 4'd1) r_state <= ISSUE;
            else               r_cnt   <= r_cnt - 4'd1;
          end
          ISSUE: begin
            if (w_issue) begin
              r_spi_tx       <= w_tx_dat;
              r_spi_tx_valid <= 1'b1;
              r_state        <= WAIT_ACCEPT;
            end
          end
          // Controller dropping ready proves it took the byte; its old rx_valid level is now stale.
          WAIT_ACCEPT: begin
            if (!i_spi_ready) r_state <= WAIT_BYTE;
          end
          WAIT_BYTE: begin
            if (i_spi_rx_valid) begin
              r_remaining <= r_remaining - 1'b1;
              if (r_remaining == 8'd1) begin
                r_cnt   <= 4'(CS_HOLD_CYCLES);
                r_state <= CS_HOLD;
              end else begin
                r_state <= ISSUE;
              end
            end
          end
          CS_HOLD: begin
            if (r_cnt == 4'd1) begin
              r_cs_n  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_cnt <= r_cnt - 4'd1;
            end
          end
          DONE: begin
            r_cs_n  <= 1'b1;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_transaction_sequencer.sv
// Directed bench for spi_transaction_sequencer with a behavioural byte-loopback controller (rx = tx ^ 0x99).
module tb_spi_transaction_sequencer;

  localparam int BYTE_T = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] cmd_len;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] spi_tx;
  logic       spi_tx_valid;
  logic       m_ready;
  logic [7:0] m_rx;
  logic       m_rx_vld;
  logic       cs_n;
  logic       busy;
  logic       done;
  logic       timeout;

  logic [7:0] m_byte;
  int         m_cnt;
  logic       m_mute = 1'b0;

  always #5 clk = ~clk;

  spi_transaction_sequencer #(
    .FIFO_DEPTH(16), .CS_SETUP_CYCLES(2), .CS_HOLD_CYCLES(2), .TIMEOUT_CYCLES(20)
  ) dut (
    .i_clk(clk), .i_rst(rst),
    .i_cmd_len(cmd_len), .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_tx_data(tx_data), .i_tx_valid(tx_valid), .o_tx_ready(tx_ready),
    .o_rx_data(rx_data), .o_rx_valid(rx_valid), .i_rx_ready(rx_ready),
    .o_spi_tx(spi_tx), .o_spi_tx_valid(spi_tx_valid), .i_spi_ready(m_ready),
    .i_spi_rx(m_rx), .i_spi_rx_valid(m_rx_vld),
    .o_cs_n(cs_n), .o_busy(busy), .o_done(done), .o_timeout(timeout)
  );

  // Controller model: takes a byte when ready, returns it XOR 0x99 after BYTE_T cycles.
  always @(posedge clk) begin
    if (rst) begin
      m_ready  <= 1'b1;
      m_rx_vld <= 1'b0;
      m_rx     <= 8'h00;
      m_cnt    <= 0;
      m_byte   <= 8'h00;
    end else if (m_ready && spi_tx_valid) begin
      m_ready  <= 1'b0;
      m_rx_vld <= 1'b0;
      m_byte   <= spi_tx;
      m_cnt    <= BYTE_T;
    end else if (!m_ready) begin
      if (m_cnt == 1) begin
        m_ready <= 1'b1;
        if (!m_mute) begin
          m_rx     <= m_byte ^ 8'h99;
          m_rx_vld <= 1'b1;
        end
      end
      m_cnt <= m_cnt - 1;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int         n_pulse = 0, n_done = 0, n_to = 0, n_cs_fall = 0, n_cs_rise = 0, n_cs_bad = 0;
  int         done_cyc = 0, to_cyc = 0, cs_fall_cyc = 0;
  logic [7:0] tx_log [64];
  int         pulse_cyc [64];
  logic       prev_cs = 1'b1;

  always @(negedge clk) begin
    if (!rst) begin
      if (spi_tx_valid) begin
        tx_log[n_pulse % 64]    = spi_tx;
        pulse_cyc[n_pulse % 64] = cyc;
        n_pulse++;
      end
      if (done) begin n_done++; done_cyc = cyc; end
      if (timeout) begin n_to++; to_cyc = cyc; end
      if (prev_cs && !cs_n) begin n_cs_fall++; cs_fall_cyc = cyc; end
      if (!prev_cs && cs_n) n_cs_rise++;
      if (!m_ready && cs_n) n_cs_bad++;
    end
    prev_cs = cs_n;
  end

  int n_cmp = 0;
  int n_bad = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    tx_data  = b;
    tx_valid = 1'b1;
    step(1);
    tx_valid = 1'b0;
  endtask

  task automatic cmd(input logic [7:0] len);
    check("cmd_ready", {31'd0, cmd_ready}, 32'd1);
    cmd_len   = len;
    cmd_valid = 1'b1;
    step(1);
    acc_cyc   = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int k = 0;
    while (n_done < target && k < budget) begin
      step(1);
      k++;
    end
  endtask

  task automatic pop_chk(input string tag, input logic [7:0] exp);
    check({tag, "_vld"}, {31'd0, rx_valid}, 32'd1);
    check(tag, {24'd0, rx_data}, {24'd0, exp});
    rx_ready = 1'b1;
    step(1);
    rx_ready = 1'b0;
  endtask

  initial begin
    int p0, d0, r0, f0;
    rst = 1'b1; cmd_len = 8'd0; cmd_valid = 1'b0; tx_data = 8'd0; tx_valid = 1'b0; rx_ready = 1'b0;
    step(3);
    check("rst_cs_n",     {31'd0, cs_n},         32'd1);
    check("rst_cmd_rdy",  {31'd0, cmd_ready},    32'd0);
    check("rst_tx_vld",   {31'd0, spi_tx_valid}, 32'd0);
    check("rst_busy",     {31'd0, busy},         32'd0);
    check("rst_done",     {31'd0, done},         32'd0);
    check("rst_timeout",  {31'd0, timeout},      32'd0);
    check("rst_rx_valid", {31'd0, rx_valid},     32'd0);
    check("rst_tx_ready", {31'd0, tx_ready},     32'd1);
    check("rst_spi_tx",   {24'd0, spi_tx},       32'd0);
    rst = 1'b0;
    step(2);

    // Single byte
    p0 = n_pulse; d0 = n_done; r0 = n_cs_rise;
    push(8'hA5);
    cmd(8'd1);
    wait_done(d0 + 1, 200);
    check("single_done", n_done, d0 + 1);
    check("single_pulses", n_pulse - p0, 1);
    check("single_tx", {24'd0, tx_log[p0]}, 32'h0000_00A5);
    check("single_cs_fall_lat", cs_fall_cyc - acc_cyc, 1);
    check("single_issue_lat", pulse_cyc[p0] - acc_cyc, 3);
    step(3);
    check("single_done_once", n_done, d0 + 1);
    check("single_cs_rise", n_cs_rise, r0 + 1);
    check("single_busy_end", {31'd0, busy}, 32'd0);
    pop_chk("single_rx", 8'h3C);
    check("single_rx_empty", {31'd0, rx_valid}, 32'd0);

    // Burst of four
    p0 = n_pulse; d0 = n_done; r0 = n_cs_rise;
    for (int i = 1; i <= 4; i++) push(8'(i));
    cmd(8'd4);
    wait_done(d0 + 1, 400);
    check("burst_done", n_done, d0 + 1);
    check("burst_pulses", n_pulse - p0, 4);
    for (int i = 0; i < 4; i++) check("burst_tx", {24'd0, tx_log[p0 + i]}, 32'(i + 1));
    check("burst_cs_one_rise", n_cs_rise, r0 + 1);
    pop_chk("burst_rx0", 8'h98);
    pop_chk("burst_rx1", 8'h9B);
    pop_chk("burst_rx2", 8'h9A);
    pop_chk("burst_rx3", 8'h9D);

    // TX underrun
    p0 = n_pulse; d0 = n_done;
    push(8'h10);
    cmd(8'd3);
    step(50);
    check("under_busy", {31'd0, busy}, 32'd1);
    check("under_cs_low", {31'd0, cs_n}, 32'd0);
    check("under_pulses", n_pulse - p0, 1);
    push(8'h11);
    push(8'h12);
    wait_done(d0 + 1, 400);
    check("under_done", n_done, d0 + 1);
    check("under_pulses_end", n_pulse - p0, 3);
    pop_chk("under_rx0", 8'h89);
    pop_chk("under_rx1", 8'h88);
    pop_chk("under_rx2", 8'h8B);
    check("cs_held_during_bytes", n_cs_bad, 0);

    // RX full blocks issue; TX full refuses a push
    p0 = n_pulse; d0 = n_done;
    for (int i = 0; i < 16; i++) push(8'h20 + 8'(i));
    check("tx_full_ready", {31'd0, tx_ready}, 32'd0);
    push(8'hEE);
    cmd(8'd16);
    wait_done(d0 + 1, 16 * 20);
    check("full_done", n_done, d0 + 1);
    check("full_pulses", n_pulse - p0, 16);
    push(8'h30);
    cmd(8'd1);
    step(30);
    check("full_stall_pulses", n_pulse - p0, 16);
    check("full_stall_busy", {31'd0, busy}, 32'd1);
    pop_chk("full_rx0", 8'hB9);
    wait_done(d0 + 2, 200);
    check("full_done2", n_done, d0 + 2);
    check("full_after_pop_tx", {24'd0, tx_log[(p0 + 16) % 64]}, 32'h0000_0030);
    for (int i = 1; i < 16; i++) pop_chk("full_rx", (8'h20 + 8'(i)) ^ 8'h99);
    pop_chk("full_rx_last", 8'hA9);

    // Zero length
    d0 = n_done; f0 = n_cs_fall;
    cmd(8'd0);
    step(3);
    check("zero_done", n_done, d0 + 1);
    check("zero_done_lat", done_cyc - acc_cyc, 1);
    check("zero_no_cs", n_cs_fall, f0);

    // Reset during byte 2 of 4
    p0 = n_pulse;
    for (int i = 0; i < 4; i++) push(8'h40 + 8'(i));
    cmd(8'd4);
    begin
      int k = 0;
      while (n_pulse < p0 + 2 && k < 200) begin step(1); k++; end
    end
    check("rstmid_reached", n_pulse - p0, 2);
    step(3);
    check("rstmid_busy", {31'd0, busy}, 32'd1);
    check("rstmid_rx_pre", {31'd0, rx_valid}, 32'd1);
    rst = 1'b1;
    step(1);
    check("rstmid_cs_n", {31'd0, cs_n}, 32'd1);
    check("rstmid_tx_ready", {31'd0, tx_ready}, 32'd1);
    check("rstmid_rx_valid", {31'd0, rx_valid}, 32'd0);
    check("rstmid_tx_vld", {31'd0, spi_tx_valid}, 32'd0);
    rst = 1'b0;
    step(2);

`ifdef SPI_SEQ_TIMEOUT_EN
    // Watchdog
    p0 = n_pulse; d0 = n_done;
    m_mute = 1'b1;
    push(8'h55);
    cmd(8'd1);
    begin
      int k = 0, t0;
      t0 = n_to;
      while (n_to == t0 && k < 200) begin step(1); k++; end
      check("to_pulse", n_to, t0 + 1);
    end
    check("to_latency", to_cyc - pulse_cyc[p0 % 64], 20);
    step(2);
    check("to_no_done", n_done, d0);
    check("to_busy", {31'd0, busy}, 32'd0);
    check("to_cs_n", {31'd0, cs_n}, 32'd1);
    check("to_idle", {31'd0, cmd_ready}, 32'd1);
    m_mute = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
